// File: rtl/bayer_quad_pkg.sv
// Shared types and constants for the Bayer 2x2 quad demosaic block.
package bayer_quad_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    EVEN_ROW = 2'd1,
    ODD_ROW  = 2'd2
  } state_t;

  // Column parity of each Bayer colour (even rows G1,R; odd rows B,G2).
  localparam logic PHASE_G1 = 1'b0;
  localparam logic PHASE_R  = 1'b1;
  localparam logic PHASE_B  = 1'b0;
  localparam logic PHASE_G2 = 1'b1;

  // Default D5M ADC width; describes the line buffer word layout {g1, r}.
  localparam int DEF_PIX_W = 12;

  typedef struct packed {
    logic [DEF_PIX_W-1:0] g1;
    logic [DEF_PIX_W-1:0] r;
  } pix_pair_t;

endpackage

// File: rtl/bayer_line_buffer.sv
// Simple dual-port line buffer: synchronous write, registered read, no content reset.
module bayer_line_buffer #(
  parameter int DEPTH  = 1296,
  parameter int WORD_W = 24,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Read data holds between reads so a stalled G2 still sees its pair.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bayer_quad_demosaic.sv
// Bayer 2x2 quad to half-resolution RGB converter for the D5M pixel stream.
// Optional frame counter port enabled by defining BAYER_QUAD_FRAME_CNT_EN.
module bayer_quad_demosaic
  import bayer_quad_pkg::*;
#(
  parameter int PIX_W    = 12,
  parameter int OUT_W    = 8,
  parameter int LINE_MAX = 2592
) (
  input  logic             ul1Clock,
  input  logic             ul1Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_sof,
  input  logic             in_eol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_r,
  output logic [OUT_W-1:0] out_g,
  output logic [OUT_W-1:0] out_b,
  output logic             out_sof,
  output logic             out_eol,
`ifdef BAYER_QUAD_FRAME_CNT_EN
  output logic [15:0]      frame_count,
`endif
  output logic             overflow
);

  localparam int DEPTH = LINE_MAX / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(LINE_MAX + 1);

  state_t             state_reg;
  logic [CW-1:0]      col_reg;
  logic [PIX_W-1:0]   g1_reg;
  logic [PIX_W-1:0]   b_reg;
  logic               sof_pending_reg;
  logic               out_valid_reg;
  logic [OUT_W-1:0]   out_r_reg, out_g_reg, out_b_reg;
  logic               out_sof_reg, out_eol_reg;
  logic               overflow_reg;

  logic               accept;
  logic               in_range;
  logic               col_phase;
  logic [AW-1:0]      pair_addr;
  logic               wr_en, rd_en, quad_load;
  logic [2*PIX_W-1:0] wr_data, rd_data;
  logic [PIX_W-1:0]   rd_g1, rd_r;
  logic [PIX_W:0]     g_sum;

  always_comb begin
    in_ready = 1'b1;
    if (state_reg == ODD_ROW) in_ready = !out_valid_reg || out_ready;
  end

  assign accept    = in_valid && in_ready;
  assign in_range  = col_reg < CW'(LINE_MAX);
  assign col_phase = col_reg[0];
  assign pair_addr = AW'(col_reg >> 1);

  // An sof pixel is always column 0 of a new even row, never part of the current row.
  assign wr_en     = accept && !in_sof && (state_reg == EVEN_ROW) && in_range && (col_phase == PHASE_R);
  assign rd_en     = accept && !in_sof && (state_reg == ODD_ROW)  && in_range && (col_phase == PHASE_B);
  assign quad_load = accept && !in_sof && (state_reg == ODD_ROW)  && in_range && (col_phase == PHASE_G2);

  assign wr_data = {g1_reg, in_data};
  assign rd_g1   = rd_data[2*PIX_W-1:PIX_W];
  assign rd_r    = rd_data[PIX_W-1:0];
  assign g_sum   = {1'b0, rd_g1} + {1'b0, in_data};

  bayer_line_buffer #(
    .DEPTH  (DEPTH),
    .WORD_W (2 * PIX_W),
    .AW     (AW)
  ) u_line_buffer (
    .clk     (ul1Clock),
    .wr_en   (wr_en),
    .wr_addr (pair_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (pair_addr),
    .rd_data (rd_data)
  );

`ifdef BAYER_QUAD_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;

  always_ff @(posedge ul1Clock) begin
    if (!ul1Reset_n) begin
      frame_cnt_reg <= 16'd0;
    end else if (accept && in_sof) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign frame_count = frame_cnt_reg;
`endif

  always_ff @(posedge ul1Clock) begin
    if (!ul1Reset_n) begin
      state_reg       <= WAIT_SOF;
      col_reg         <= '0;
      g1_reg          <= '0;
      b_reg           <= '0;
      sof_pending_reg <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_r_reg       <= '0;
      out_g_reg       <= '0;
      out_b_reg       <= '0;
      out_sof_reg     <= 1'b0;
      out_eol_reg     <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;

      if (quad_load) begin
        out_valid_reg   <= 1'b1;
        out_r_reg       <= rd_r[PIX_W-1 -: OUT_W];
        out_g_reg       <= g_sum[PIX_W -: OUT_W];
        out_b_reg       <= b_reg[PIX_W-1 -: OUT_W];
        out_sof_reg     <= sof_pending_reg;
        out_eol_reg     <= in_eol;
        sof_pending_reg <= 1'b0;
      end

      if (accept) begin
        if (in_sof) begin
          g1_reg          <= in_data;
          overflow_reg    <= 1'b0;
          sof_pending_reg <= 1'b1;
          if (in_eol) begin
            state_reg <= ODD_ROW;
            col_reg   <= '0;
          end else begin
            state_reg <= EVEN_ROW;
            col_reg   <= CW'(1);
          end
        end else if (state_reg != WAIT_SOF) begin
          if (!in_range) overflow_reg <= 1'b1;
          if (state_reg == EVEN_ROW && in_range && col_phase == PHASE_G1) g1_reg <= in_data;
          if (state_reg == ODD_ROW && in_range && col_phase == PHASE_B) b_reg <= in_data;
          if (in_eol) begin
            col_reg   <= '0;
            state_reg <= (state_reg == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
          end else if (in_range) begin
            col_reg <= col_reg + CW'(1);
          end
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_r     = out_r_reg;
  assign out_g     = out_g_reg;
  assign out_b     = out_b_reg;
  assign out_sof   = out_sof_reg;
  assign out_eol   = out_eol_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_bayer_quad_demosaic.sv
// Bench for bayer_quad_demosaic: row-level quad model, scoreboard and directed frames.
module tb_bayer_quad_demosaic;

  localparam int PIX_W    = 12;
  localparam int OUT_W    = 8;
  localparam int LINE_MAX = 64;

  typedef struct {
    int r;
    int g;
    int b;
    bit sof;
    bit eol;
  } quad_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PIX_W-1:0] in_data = '0;
  logic             in_sof = 1'b0;
  logic             in_eol = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] out_r, out_g, out_b;
  logic             out_sof, out_eol;
  logic             overflow;
`ifdef BAYER_QUAD_FRAME_CNT_EN
  logic [15:0]      frame_count;
`endif

  bayer_quad_demosaic #(
    .PIX_W    (PIX_W),
    .OUT_W    (OUT_W),
    .LINE_MAX (LINE_MAX)
  ) dut (
    .ul1Clock   (clk),
    .ul1Reset_n (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sof     (in_sof),
    .in_eol     (in_eol),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_r      (out_r),
    .out_g      (out_g),
    .out_b      (out_b),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
`ifdef BAYER_QUAD_FRAME_CNT_EN
    .frame_count(frame_count),
`endif
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  bit    rand_ready = 1'b0;
  quad_t exp_q[$];
  quad_t log_q[$];
  int    even_px[0:127];
  int    odd_px[0:127];
  int    even_len = 0;
  bit    sof_model = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: sets out_ready each cycle, checks holds and transfers.
  initial begin
    bit    hold_valid;
    quad_t held;
    quad_t e;
    hold_valid = 1'b0;
    forever begin
      @(negedge clk);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (hold_valid) begin
        n_checks++;
        if (!out_valid || int'(out_r) != held.r || int'(out_g) != held.g || int'(out_b) != held.b ||
            out_sof != held.sof || out_eol != held.eol) begin
          n_fail++;
          $display("FAIL hold_stable: got v=%0b r=%0h g=%0h b=%0h expected r=%0h g=%0h b=%0h",
                   out_valid, out_r, out_g, out_b, held.r, held.g, held.b);
        end
      end
      hold_valid = 1'b0;
      if (out_valid && out_ready) begin
        e.r = out_r; e.g = out_g; e.b = out_b; e.sof = out_sof; e.eol = out_eol;
        log_q.push_back(e);
        $display("quad r=%02h g=%02h b=%02h sof=%0b eol=%0b", out_r, out_g, out_b, out_sof, out_eol);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_quad: got r=%0h g=%0h b=%0h expected none", out_r, out_g, out_b);
        end else begin
          held = exp_q.pop_front();
          n_checks++;
          if (e.r != held.r || e.g != held.g || e.b != held.b || e.sof != held.sof || e.eol != held.eol) begin
            n_fail++;
            $display("FAIL quad: got r=%0h g=%0h b=%0h sof=%0b eol=%0b expected r=%0h g=%0h b=%0h sof=%0b eol=%0b",
                     e.r, e.g, e.b, e.sof, e.eol, held.r, held.g, held.b, held.sof, held.eol);
          end
        end
      end else if (out_valid) begin
        hold_valid = 1'b1;
        held.r = out_r; held.g = out_g; held.b = out_b; held.sof = out_sof; held.eol = out_eol;
      end
    end
  end

  task automatic send_pix(input int d, input bit s, input bit e);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = PIX_W'(d); in_sof = s; in_eol = e;
    #2;
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
  endtask

  // Row model: an odd row pairs with the stored even row, one RGB quad per complete 2x2 block.
  task automatic send_row(input int len, input bit sof, input bit odd, input bit eol);
    int n;
    quad_t q;
    if (sof) sof_model = 1'b1;
    if (odd) begin
      n = len;
      if (even_len < n) n = even_len;
      if (LINE_MAX < n) n = LINE_MAX;
      n = n / 2;
      for (int j = 0; j < n; j++) begin
        q.r = even_px[2*j+1] >> 4;
        q.g = (even_px[2*j] + odd_px[2*j+1]) >> 5;
        q.b = odd_px[2*j] >> 4;
        q.sof = sof_model;
        sof_model = 1'b0;
        q.eol = eol && (len % 2 == 0) && (len <= LINE_MAX) && (j == n - 1);
        exp_q.push_back(q);
      end
    end else begin
      even_len = len;
    end
    for (int i = 0; i < len; i++)
      send_pix(odd ? odd_px[i] : even_px[i], sof && i == 0, eol && i == len - 1);
  endtask

  task automatic fill_rand(input int len);
    for (int i = 0; i < len; i++) begin
      even_px[i] = $urandom_range(0, 4095);
      odd_px[i]  = $urandom_range(0, 4095);
    end
  endtask

  task automatic drain();
    int t;
    idle();
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic frame_4x2();
    even_px[0] = 'h800; even_px[1] = 'hFFF; even_px[2] = 'h400; even_px[3] = 'h010;
    odd_px[0]  = 'h000; odd_px[1]  = 'h800; odd_px[2]  = 'h123; odd_px[3]  = 'h400;
    send_row(4, 1'b1, 1'b0, 1'b1);
    send_row(4, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_rgb", {out_r, out_g, out_b}, 0);
    check("reset_sof_eol", {out_sof, out_eol}, 0);
    check("reset_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pixels before the first sof are discarded.
    for (int i = 0; i < 6; i++) send_pix(i * 300, 1'b0, i == 2 || i == 5);
    drain();
    check("pre_sof_quads", log_q.size(), 0);

    // Hand-computed 4x2 frame.
    log_q.delete();
    frame_4x2();
    drain();
    check("lit_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("lit_q0_r", log_q[0].r, 'hFF);
      check("lit_q0_g", log_q[0].g, 'h80);
      check("lit_q0_b", log_q[0].b, 'h00);
      check("lit_q0_sof_eol", {log_q[0].sof, log_q[0].eol}, 2'b10);
      check("lit_q1_r", log_q[1].r, 'h01);
      check("lit_q1_g", log_q[1].g, 'h40);
      check("lit_q1_b", log_q[1].b, 'h12);
      check("lit_q1_sof_eol", {log_q[1].sof, log_q[1].eol}, 2'b01);
    end

    // Mid-row sof resync: the odd row stops after B,G2,B.
    log_q.delete();
    fill_rand(4);
    send_row(4, 1'b1, 1'b0, 1'b1);
    send_row(3, 1'b0, 1'b1, 1'b0);
    frame_4x2();
    drain();
    check("resync_count", log_q.size(), 3);

    // 64x4 frame under random backpressure.
    log_q.delete();
    rand_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      fill_rand(64);
      send_row(64, r == 0, 1'b0, 1'b1);
      send_row(64, 1'b0, 1'b1, 1'b1);
    end
    drain();
    rand_ready = 1'b0;
    check("rand_count", log_q.size(), 64);

    // Odd-length lines: trailing B is dropped with no eol quad.
    log_q.delete();
    for (int r = 0; r < 2; r++) begin
      fill_rand(5);
      send_row(5, r == 0, 1'b0, 1'b1);
      send_row(5, 1'b0, 1'b1, 1'b1);
    end
    drain();
    check("odd_len_count", log_q.size(), 4);

    // Over-long lines.
    log_q.delete();
    fill_rand(LINE_MAX + 4);
    send_row(LINE_MAX + 4, 1'b1, 1'b0, 1'b1);
    send_row(LINE_MAX + 4, 1'b0, 1'b1, 1'b1);
    drain();
    check("ovf_set", overflow, 1);
    check("ovf_count", log_q.size(), LINE_MAX / 2);
    frame_4x2();
    drain();
    check("ovf_cleared", overflow, 0);

`ifdef BAYER_QUAD_FRAME_CNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("fc_reset", frame_count, 0);
    rst_n = 1'b1;
    for (int f = 0; f < 3; f++) frame_4x2();
    drain();
    check("fc_three", frame_count, 3);
    @(negedge clk);
    force dut.frame_cnt_reg = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_reg;
    frame_4x2();
    drain();
    check("fc_wrap", frame_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
